sdram_arbiter: RTL and testbench



---
 rtl/sdram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM sequencer between video line fetch, CPU byte access and auto-refresh.
// Latency: request sampled in IDLE at cycle N -> seq_start at N+1; grant held through the seq_done cycle.
// Backpressure: requesters hold req until their done pulse; the sequencer paces us via seq_done. CPU aging under SDRAM_ARBITER_CPU_AGING_EN.
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 780,
    parameter int URGENT_LEVEL   = 4,
    parameter int CPU_MAX_WAIT   = 64
) (
    input  logic        clock_100_mhz,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [24:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [25:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic        seq_start,
    output logic [1:0]  seq_op,
    output logic [25:0] seq_addr,
    input  logic        seq_done,
    output logic        ref_overflow
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_REF  = 2'd3;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_LINE = 2'b10;
    localparam logic [1:0] OP_REF  = 2'b11;

    localparam int             TW         = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(REFRESH_PERIOD - 1);
    localparam logic [2:0]     URGENT_CNT = 3'(URGENT_LEVEL);

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    op_q, op_d;
    logic [25:0]   addr_q, addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          drain_q, drain_d;

    logic [1:0]    pick_own;
    logic [1:0]    pick_op;
    logic [25:0]   pick_addr;
    logic          ref_urgent;
    logic          ref_tick;
    logic          ref_done;
    logic          busy;
    logic          cpu_aged;

    assign busy       = (state_q == ST_BUSY);
    assign ref_tick   = (timer_q == TIMER_LAST);
    assign ref_done   = busy && seq_done && (owner_q == OWN_REF);
    // Once the backlog reaches the urgent level, refresh keeps top rank until the backlog is empty.
    assign ref_urgent = (pending_q >= URGENT_CNT) || (drain_q && (pending_q != 3'd0));

    assign seq_start    = (state_q == ST_START);
    assign seq_op       = op_q;
    assign seq_addr     = addr_q;
    assign vid_gnt      = (state_q != ST_IDLE) && (owner_q == OWN_VID);
    assign cpu_gnt      = (state_q != ST_IDLE) && (owner_q == OWN_CPU);
    assign vid_done     = busy && seq_done && (owner_q == OWN_VID);
    assign cpu_done     = busy && seq_done && (owner_q == OWN_CPU);
    assign ref_overflow = ovf_q;

`ifdef SDRAM_ARBITER_CPU_AGING_EN
    localparam int            WW       = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

    logic [WW-1:0] cpu_wait_q, cpu_wait_d;
    logic          cpu_win;

    assign cpu_aged = cpu_req && (cpu_wait_q == WAIT_MAX);
    assign cpu_win  = (state_q == ST_IDLE) && (pick_own == OWN_CPU);

    // CPU wait counter: counts ungranted request cycles, saturates, clears on grant or withdrawal.
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (cpu_win || !cpu_req) begin
            cpu_wait_d = '0;
        end else if (!cpu_gnt && (cpu_wait_q != WAIT_MAX)) begin
            cpu_wait_d = cpu_wait_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clock_100_mhz) begin
        if (reset) begin
            cpu_wait_q <= '0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
        end
    end
`else
    assign cpu_aged = 1'b0;
`endif

    // Winner selection: urgent refresh, aged CPU, video, CPU, then background refresh.
    always_comb begin
        pick_own  = OWN_NONE;
        pick_op   = OP_RD;
        pick_addr = '0;
        if (ref_urgent) begin
            pick_own = OWN_REF;
            pick_op  = OP_REF;
        end else if (cpu_aged) begin
            pick_own  = OWN_CPU;
            pick_op   = cpu_we ? OP_WR : OP_RD;
            pick_addr = cpu_addr;
        end else if (vid_req) begin
            pick_own  = OWN_VID;
            pick_op   = OP_LINE;
            pick_addr = {vid_addr, 1'b0};
        end else if (cpu_req) begin
            pick_own  = OWN_CPU;
            pick_op   = cpu_we ? OP_WR : OP_RD;
            pick_addr = cpu_addr;
        end else if (pending_q != 3'd0) begin
            pick_own = OWN_REF;
            pick_op  = OP_REF;
        end
    end

    // Transaction FSM: latch the winner on IDLE->START and hold it until seq_done.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_own != OWN_NONE) begin
                    state_d = ST_START;
                    owner_d = pick_own;
                    op_d    = pick_op;
                    addr_d  = pick_addr;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (seq_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Refresh timer, pending backlog, drain episode and sticky overflow.
    always_comb begin
        timer_d   = ref_tick ? '0 : timer_q + 1'b1;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (ref_tick && !ref_done) begin
            if (pending_q == 3'd7) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + 3'd1;
            end
        end else if (ref_done && !ref_tick) begin
            pending_d = pending_q - 3'd1;
        end
        if (pending_q >= URGENT_CNT) begin
            drain_d = 1'b1;
        end else if (pending_q == 3'd0) begin
            drain_d = 1'b0;
        end else begin
            drain_d = drain_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_100_mhz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            op_q      <= 2'b00;
            addr_q    <= '0;
            timer_q   <= '0;
            pending_q <= 3'd0;
            ovf_q     <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            drain_q   <= drain_d;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed vectors, multi-cycle corner sequences and randomized traffic vs a reference model.
// Latency: checks seq_start one cycle after a request is sampled in IDLE.
// Backpressure: the bench plays the sequencer and drives seq_done itself.
module tb_sdram_arbiter;
    localparam int RP = 780;
`ifdef SDRAM_ARBITER_CPU_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0;
    logic [24:0] vid_addr = '0;
    logic        vid_gnt, vid_done;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [25:0] cpu_addr = '0;
    logic        cpu_gnt, cpu_done;
    logic        seq_start;
    logic [1:0]  seq_op;
    logic [25:0] seq_addr;
    logic        seq_done = 1'b0;
    logic        ref_overflow;

    always #5 clk = ~clk;

    sdram_arbiter #(.REFRESH_PERIOD(RP), .URGENT_LEVEL(4), .CPU_MAX_WAIT(64)) dut (
        .clock_100_mhz(clk),
        .reset(reset),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_gnt(vid_gnt),
        .vid_done(vid_done),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_gnt(cpu_gnt),
        .cpu_done(cpu_done),
        .seq_start(seq_start),
        .seq_op(seq_op),
        .seq_addr(seq_addr),
        .seq_done(seq_done),
        .ref_overflow(ref_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All outputs packed: {start, op, addr, vgnt, cgnt, vdone, cdone, ovf}
    function automatic logic [33:0] outs();
        return {seq_start, seq_op, seq_addr, vid_gnt, cpu_gnt, vid_done, cpu_done, ref_overflow};
    endfunction

    function automatic logic [33:0] mk(input logic st, input logic [1:0] op, input logic [25:0] ad,
                                       input logic vg, input logic cg, input logic vd, input logic cd);
        return {st, op, ad, vg, cg, vd, cd, 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        seq_done = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        vr;
        logic [24:0] va;
        logic        cr;
        logic        cw;
        logic [25:0] ca;
        logic        sd;
        logic [33:0] exp;
    } vec_t;

    vec_t tv [17];

    // ---------------- reference model (transaction view) ----------------
    int          m_phase;   // -1 free, 0 command cycle, >=1 cycles into transaction
    int          m_owner;   // 0 video, 1 cpu, 2 refresh
    logic [1:0]  m_op;
    logic [25:0] m_addr;
    int          m_pend;
    bit          m_ovf;
    bit          m_episode; // urgent backlog being worked off
    int          m_wait;
    int          m_cyc;

    task automatic model_reset();
        m_phase = -1; m_owner = 0; m_op = 2'b00; m_addr = '0;
        m_pend = 0; m_ovf = 1'b0; m_episode = 1'b0; m_wait = 0; m_cyc = 0;
    endtask

    function automatic logic [33:0] model_exp();
        bit act = (m_phase >= 0);
        bit fin = seq_done && (m_phase >= 1);
        return {m_phase == 0, m_op, m_addr, act && m_owner == 0, act && m_owner == 1,
                fin && m_owner == 0, fin && m_owner == 1, m_ovf};
    endfunction

    task automatic model_step();
        bit tick, rdone, urgent, aged, cpu_owns;
        int winner;
        if (reset) begin
            model_reset();
            return;
        end
        tick     = (m_cyc % RP) == (RP - 1);
        rdone    = seq_done && (m_phase >= 1) && (m_owner == 2);
        urgent   = (m_pend >= 4) || (m_episode && m_pend > 0);
        aged     = AGING && cpu_req && (m_wait >= 64);
        cpu_owns = (m_phase >= 0) && (m_owner == 1);
        winner   = -1;
        if (m_phase < 0) begin
            if (urgent) winner = 2;
            else if (aged) winner = 1;
            else if (vid_req) winner = 0;
            else if (cpu_req) winner = 1;
            else if (m_pend > 0) winner = 2;
        end
        if (m_pend >= 4) m_episode = 1'b1;
        else if (m_pend == 0) m_episode = 1'b0;
        if (winner == 1 || !cpu_req) m_wait = 0;
        else if (!cpu_owns && m_wait < 64) m_wait++;
        if (tick && !rdone) begin
            if (m_pend == 7) m_ovf = 1'b1;
            else m_pend++;
        end else if (rdone && !tick) begin
            m_pend--;
        end
        if (m_phase < 0) begin
            if (winner >= 0) begin
                m_phase = 0;
                m_owner = winner;
                case (winner)
                    0: begin m_op = 2'b10; m_addr = {vid_addr, 1'b0}; end
                    1: begin m_op = cpu_we ? 2'b01 : 2'b00; m_addr = cpu_addr; end
                    default: begin m_op = 2'b11; m_addr = '0; end
                endcase
            end
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (seq_done) begin
            m_phase = -1;
        end else begin
            m_phase++;
        end
        m_cyc++;
    endtask

    initial begin
        int first_cpu;
        int w;
        logic give;
        logic [27:0] exp_oa;

        // Basic CPU write, then video/CPU contention, then stray seq_done in IDLE.
        tv[0]  = '{1'b0, 25'h0,   1'b0, 1'b0, 26'h0,  1'b0, mk(0, 2'b00, 26'h0,   0, 0, 0, 0)};
        tv[1]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(0, 2'b00, 26'h0,   0, 0, 0, 0)};
        tv[2]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(1, 2'b01, 26'h5,   0, 1, 0, 0)};
        tv[3]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(0, 2'b01, 26'h5,   0, 1, 0, 0)};
        tv[4]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(0, 2'b01, 26'h5,   0, 1, 0, 0)};
        tv[5]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(0, 2'b01, 26'h5,   0, 1, 0, 0)};
        tv[6]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b0, mk(0, 2'b01, 26'h5,   0, 1, 0, 0)};
        tv[7]  = '{1'b0, 25'h0,   1'b1, 1'b1, 26'h5,  1'b1, mk(0, 2'b01, 26'h5,   0, 1, 0, 1)};
        tv[8]  = '{1'b0, 25'h0,   1'b0, 1'b0, 26'h0,  1'b0, mk(0, 2'b01, 26'h5,   0, 0, 0, 0)};
        tv[9]  = '{1'b1, 25'h102, 1'b1, 1'b0, 26'h33, 1'b0, mk(0, 2'b01, 26'h5,   0, 0, 0, 0)};
        tv[10] = '{1'b1, 25'h102, 1'b1, 1'b0, 26'h33, 1'b0, mk(1, 2'b10, 26'h204, 1, 0, 0, 0)};
        tv[11] = '{1'b1, 25'h102, 1'b1, 1'b0, 26'h33, 1'b1, mk(0, 2'b10, 26'h204, 1, 0, 1, 0)};
        tv[12] = '{1'b0, 25'h0,   1'b1, 1'b0, 26'h33, 1'b0, mk(0, 2'b10, 26'h204, 0, 0, 0, 0)};
        tv[13] = '{1'b0, 25'h0,   1'b1, 1'b0, 26'h33, 1'b0, mk(1, 2'b00, 26'h33,  0, 1, 0, 0)};
        tv[14] = '{1'b0, 25'h0,   1'b1, 1'b0, 26'h33, 1'b1, mk(0, 2'b00, 26'h33,  0, 1, 0, 1)};
        tv[15] = '{1'b0, 25'h0,   1'b0, 1'b0, 26'h0,  1'b1, mk(0, 2'b00, 26'h33,  0, 0, 0, 0)};
        tv[16] = '{1'b0, 25'h0,   1'b0, 1'b0, 26'h0,  1'b0, mk(0, 2'b00, 26'h33,  0, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            vid_req = tv[i].vr; vid_addr = tv[i].va;
            cpu_req = tv[i].cr; cpu_we = tv[i].cw; cpu_addr = tv[i].ca;
            seq_done = tv[i].sd;
            #2;
            check($sformatf("vec%0d", i), 64'(outs()), 64'(tv[i].exp));
            cyc();
        end

        // Four ticks of backlog while the CPU holds the sequencer: four refreshes precede video.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 26'h10;
        repeat (4 * RP + 20) cyc();
        vid_req = 1'b1; vid_addr = 25'h0ABC; seq_done = 1'b1;
        #2;
        check("backlog_cpu_done", 64'(cpu_done), 64'd1);
        cyc();
        seq_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!seq_start && w < 20) begin
                cyc();
                w++;
            end
            check($sformatf("backlog_start%0d", k), 64'(seq_start), 64'd1);
            exp_oa = (k < 4) ? {2'b11, 26'h0} : {2'b10, 26'h1578};
            check($sformatf("backlog_op%0d", k), 64'({seq_op, seq_addr}), 64'(exp_oa));
            cyc();
            seq_done = 1'b1;
            cyc();
            seq_done = 1'b0;
        end
        vid_req = 1'b0; cpu_req = 1'b0;

        // Sequencer never finishes: the eighth tick overflows the backlog.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 26'h20;
        repeat (7 * RP + 10) cyc();
        check("ovf_before", 64'(ref_overflow), 64'd0);
        repeat (RP) cyc();
        check("ovf_set", 64'(ref_overflow), 64'd1);
        seq_done = 1'b1;
        cyc();
        seq_done = 1'b0; cpu_req = 1'b0;
        repeat (50) cyc();
        check("ovf_sticky", 64'(ref_overflow), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("ovf_reset", 64'(outs()), 64'd0);

        // Reset in the middle of a transaction abandons it silently.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 26'h7;
        cyc();
        cyc();
        check("midreset_busy", 64'(cpu_gnt), 64'd1);
        reset = 1'b1; cpu_req = 1'b0;
        cyc();
        check("midreset_outs", 64'(outs()), 64'd0);
        reset = 1'b0; seq_done = 1'b1;
        #2;
        check("midreset_stray_done", 64'(outs()), 64'd0);
        cyc();
        seq_done = 1'b0;
        check("midreset_idle", 64'(outs()), 64'd0);

        // Video hogging the sequencer: aging lets the CPU through, strict priority starves it.
        do_reset();
        vid_req = 1'b1; vid_addr = 25'h40; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 26'h99;
        first_cpu = -1;
        give = 1'b0;
        for (int t = 0; t < 300; t++) begin
            seq_done = give;
            give = seq_start;
            if (cpu_gnt && first_cpu < 0) first_cpu = t;
            cyc();
        end
        seq_done = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        if (AGING) check("aging_grant_window", 64'(first_cpu >= 65 && first_cpu <= 70), 64'd1);
        else check("strict_cpu_starved", 64'(first_cpu), 64'(-1));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(7) == 0) vid_req = ~vid_req;
            if ($urandom_range(7) == 0) cpu_req = ~cpu_req;
            cpu_we   = 1'($urandom);
            vid_addr = 25'($urandom);
            cpu_addr = 26'($urandom);
            seq_done = ($urandom_range(3) == 0);
            reset    = ($urandom_range(599) == 0);
            #2;
            check($sformatf("rand%0d", t), 64'(outs()), 64'(model_exp()));
            model_step();
            cyc();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
